// File: rtl/stk_pipe_ad.sv
// stk_pipe_ad: command intake with descriptor allocation, one-cycle pointer
// lookup and a credit-protected output FIFO.

package stk_pkg;
  localparam int PTR_W = 8;
endpackage

module stk_pipe_ad #(
  parameter int DATA_W    = 32,
  parameter int PTR_W     = stk_pkg::PTR_W,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_cmd_vld,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_cmd_rdy,
  output logic              o_ad_alloc,
  input  logic              i_ad_empty_r,
  input  logic              i_ad_busy_r,
  input  logic [PTR_W-1:0]  i_lk_ptr_w,
  output logic              o_out_vld,
  output logic [PTR_W-1:0]  o_out_ptr,
  output logic [DATA_W-1:0] o_out_data,
  input  logic              i_out_rdy,
  output logic [15:0]       o_alloc_cnt_r
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PTR_W + DATA_W;
  localparam logic [CW-1:0] CRED_ONE = CW'(1);
  localparam logic [CW-1:0] CRED_MAX = CW'(OUT_DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              run_en;
  logic [CW-1:0]     credit_q, credit_d;
  logic              lk_vld_q;
  logic [DATA_W-1:0] lk_data_q;
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]     mem_q [OUT_DEPTH];
  logic [EW-1:0]     head;
  logic [15:0]       alloc_cnt_q;
  logic              accept;
  logic              pop;
  logic              push;

  // State register: INIT until the allocator finishes initializing, then RUN forever.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and intake handshake; accepting already in the cycle busy drops.
  always_comb begin
    state_d = state_q;
    run_en  = 1'b0;
    if (state_q == ST_INIT && !i_ad_busy_r) begin
      state_d = ST_RUN;
    end
    // Held low while reset is asserted so nothing is offered during reset.
    run_en    = arst_n & (state_d == ST_RUN);
    o_cmd_rdy = run_en & ~i_ad_empty_r & (credit_q != '0);
  end

  assign accept     = i_cmd_vld & o_cmd_rdy;
  assign o_ad_alloc = accept;
  assign pop        = o_out_vld & i_out_rdy;
  assign push       = lk_vld_q;

  // Credit tracks free FIFO slots minus lookups still in flight.
  always_comb begin
    credit_d = credit_q;
    if (accept && !pop) begin
      credit_d = credit_q - CRED_ONE;
    end else if (pop && !accept) begin
      credit_d = credit_q + CRED_ONE;
    end
  end

  // Control registers: credit, lookup valid, FIFO pointers and allocation count.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      credit_q    <= CRED_MAX;
      lk_vld_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      alloc_cnt_q <= '0;
    end else begin
      credit_q <= credit_d;
      lk_vld_q <= accept;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (accept && alloc_cnt_q != 16'hFFFF) begin
        alloc_cnt_q <= alloc_cnt_q + 16'd1;
      end
    end
  end

  // Datapath storage: lookup payload and FIFO entries carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lk_data_q <= i_cmd_data;
    end
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {i_lk_ptr_w, lk_data_q};
    end
  end

  // Head of the FIFO is read directly so a new entry shows the cycle after its write.
  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign o_out_vld     = (wr_ptr_q != rd_ptr_q);
  assign o_out_ptr     = head[EW-1:DATA_W];
  assign o_out_data    = head[DATA_W-1:0];
  assign o_alloc_cnt_r = alloc_cnt_q;

endmodule

// File: tb/tb_stk_pipe_ad.sv
// Bench for stk_pipe_ad: randomized and directed stimulus, outstanding-count
// reference model, output scoreboard with a separate monitor.

module tb_stk_pipe_ad;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        i_cmd_vld = 1'b0;
  logic [31:0] i_cmd_data = '0;
  logic        o_cmd_rdy;
  logic        o_ad_alloc;
  logic        i_ad_empty_r = 1'b0;
  logic        i_ad_busy_r = 1'b1;
  logic [7:0]  i_lk_ptr_w = '0;
  logic        o_out_vld;
  logic [7:0]  o_out_ptr;
  logic [31:0] o_out_data;
  logic        i_out_rdy = 1'b0;
  logic [15:0] o_alloc_cnt_r;

  int          n_cmp = 0;
  int          n_err = 0;

  // reference model state
  logic [39:0] exp_q[$];
  int          outst = 0;
  int          acc_prev = 0;
  logic [15:0] alloc_m = '0;
  logic        run_m = 1'b0;
  logic [7:0]  nxt_ptr = '0;
  int          acc_seen = 0;

  stk_pipe_ad #(.DATA_W(32), .PTR_W(8), .OUT_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .i_cmd_vld     (i_cmd_vld),
    .i_cmd_data    (i_cmd_data),
    .o_cmd_rdy     (o_cmd_rdy),
    .o_ad_alloc    (o_ad_alloc),
    .i_ad_empty_r  (i_ad_empty_r),
    .i_ad_busy_r   (i_ad_busy_r),
    .i_lk_ptr_w    (i_lk_ptr_w),
    .o_out_vld     (o_out_vld),
    .o_out_ptr     (o_out_ptr),
    .o_out_data    (o_out_data),
    .i_out_rdy     (i_out_rdy),
    .o_alloc_cnt_r (o_alloc_cnt_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check handshake against the model, update it.
  task automatic step(input logic vld, input logic [31:0] data, input logic busy,
                      input logic empty, input logic ordy, input int ptr_sel);
    logic erdy, evld, acc, pop;
    @(posedge clk); #1;
    i_cmd_vld    = vld;
    i_cmd_data   = data;
    i_ad_busy_r  = busy;
    i_ad_empty_r = empty;
    i_out_rdy    = ordy;
    i_lk_ptr_w   = nxt_ptr;
    nxt_ptr      = (ptr_sel >= 0) ? 8'(ptr_sel) : 8'($urandom);
    @(negedge clk);
    erdy = (run_m || !busy) && !empty && (outst < DEPTH);
    evld = (outst - acc_prev) > 0;
    chk("cmd_rdy", o_cmd_rdy, erdy);
    chk("ad_alloc", o_ad_alloc, vld && erdy);
    chk("out_vld", o_out_vld, evld);
    chk("alloc_cnt", o_alloc_cnt_r, alloc_m);
    if (o_ad_alloc) acc_seen++;
    acc = vld && erdy;
    pop = evld && ordy;
    if (acc) begin
      exp_q.push_back({nxt_ptr, data});
      if (alloc_m != 16'hFFFF) alloc_m = alloc_m + 16'd1;
    end
    outst    = outst + int'(acc) - int'(pop);
    acc_prev = int'(acc);
    if (!busy) run_m = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, -1);
  endtask

  // Asynchronous reset in mid-cycle with commands offered; outputs must drop at once.
  task automatic do_reset(input logic busy_after);
    @(posedge clk); #1;
    i_cmd_vld = 1'b1; i_ad_busy_r = 1'b0; i_ad_empty_r = 1'b0; i_out_rdy = 1'b1;
    #2 arst_n = 1'b0;
    #1;
    chk("rst_cmd_rdy", o_cmd_rdy, 0);
    chk("rst_ad_alloc", o_ad_alloc, 0);
    chk("rst_out_vld", o_out_vld, 0);
    chk("rst_alloc_cnt", o_alloc_cnt_r, 0);
    exp_q.delete();
    outst = 0; acc_prev = 0; alloc_m = '0; run_m = 1'b0;
    @(posedge clk); #1;
    i_cmd_vld = 1'b0; i_ad_busy_r = busy_after;
    @(posedge clk); #1;
    arst_n = 1'b1;
    if (!busy_after) run_m = 1'b1;
  endtask

  // Monitor: whenever the DUT presents a head, compare it to the oldest expected entry.
  always @(negedge clk) begin
    if (arst_n && o_out_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_spurious: got ptr=%0h data=%0h, required no output", o_out_ptr, o_out_data);
      end else begin
        chk("out_ptr", o_out_ptr, exp_q[0][39:32]);
        chk("out_data", o_out_data, exp_q[0][31:0]);
        if (i_out_rdy) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    do_reset(1'b1);

    // allocator initializing: nothing accepted until busy drops
    repeat (10) step(1'b1, $urandom, 1'b1, 1'b0, 1'b1, -1);
    step(1'b1, $urandom, 1'b0, 1'b0, 1'b1, -1);
    chk("init_rdy_on_drop", o_cmd_rdy, 1);
    $display("init: busy phase done, accept on busy drop");

    // two-cycle latency with fixed data/pointer
    drain(6);
    step(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0, 'h12);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, -1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, -1);
    chk("lat_vld", o_out_vld, 1);
    chk("lat_ptr", o_out_ptr, 8'h12);
    chk("lat_data", o_out_data, 32'hA5);
    $display("latency: ptr=%0h data=%0h", o_out_ptr, o_out_data);

    // backpressure: credit limits to DEPTH accepts, one pop frees one
    drain(6);
    acc_seen = 0;
    repeat (8) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, -1);
    chk("bp_accepts", acc_seen, DEPTH);
    chk("bp_rdy_low", o_cmd_rdy, 0);
    acc_seen = 0;
    step(1'b1, $urandom, 1'b0, 1'b0, 1'b1, -1);
    repeat (3) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, -1);
    chk("bp_one_more", acc_seen, 1);
    $display("backpressure: one extra accept after pop = %0d", acc_seen);

    // empty pool blocks allocation, resumes on deassert
    drain(6);
    acc_seen = 0;
    repeat (5) step(1'b1, $urandom, 1'b0, 1'b1, 1'b1, -1);
    chk("empty_no_alloc", acc_seen, 0);
    step(1'b1, $urandom, 1'b0, 1'b0, 1'b1, -1);
    chk("empty_resume", acc_seen, 1);
    $display("empty pool: resume accepts = %0d", acc_seen);

    // full throughput after a fresh reset
    do_reset(1'b0);
    acc_seen = 0;
    repeat (100) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1, -1);
    chk("thr_accepts", acc_seen, 100);
    drain(4);
    chk("thr_cnt", o_alloc_cnt_r, 100);
    chk("thr_credit", dut.credit_q, DEPTH);
    chk("thr_all_out", exp_q.size(), 0);
    $display("throughput: accepts=%0d cnt=%0d", acc_seen, o_alloc_cnt_r);

    // reset with three entries queued
    repeat (3) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, -1);
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, -1);
    chk("pre_rst_vld", o_out_vld, 1);
    do_reset(1'b0);
    drain(3);
    step(1'b1, 32'h3C, 1'b0, 1'b0, 1'b0, 'h77);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, -1);
    chk("rst_lat_early", o_out_vld, 0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, -1);
    chk("rst_lat_vld", o_out_vld, 1);
    chk("rst_lat_data", o_out_data, 32'h3C);
    $display("mid reset: new entry ptr=%0h data=%0h", o_out_ptr, o_out_data);

    // randomized traffic
    repeat (400) step(1'($urandom_range(0, 1)), $urandom, 1'b0,
                      ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), -1);
    drain(8);
    chk("rand_all_out", exp_q.size(), 0);
    $display("random: done, alloc_cnt=%0d", o_alloc_cnt_r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stk_pipe_ad.md
STK_PIPE_AD -- requirements
Module: stk_pipe_ad

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the command payload width in bits.
REQ-002 SHALL have parameter PTR_W, default 8, giving the descriptor pointer width; it SHALL equal stk_pkg::PTR_W.
REQ-003 SHALL have parameter OUT_DEPTH, default 4, giving the number of output FIFO entries, a power of two, minimum 2.
REQ-004 Port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-005 Port arst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port i_cmd_vld, input, 1 bit: a command is present.
REQ-007 Port i_cmd_data, input, DATA_W bits: the command payload.
REQ-008 Port o_cmd_rdy, output, 1 bit: the block accepts a command this cycle.
REQ-009 Port o_ad_alloc, output, 1 bit: allocation request to the allocator.
REQ-010 Port i_ad_empty_r, input, 1 bit: the free pool has no descriptors.
REQ-011 Port i_ad_busy_r, input, 1 bit: the allocator is initializing.
REQ-012 Port i_lk_ptr_w, input, PTR_W bits: the allocated pointer, valid in the cycle after o_ad_alloc.
REQ-013 Port o_out_vld, output, 1 bit: the output FIFO head is valid.
REQ-014 Port o_out_ptr, output, PTR_W bits: the head pointer.
REQ-015 Port o_out_data, output, DATA_W bits: the head payload.
REQ-016 Port i_out_rdy, input, 1 bit: the consumer accepts the head.
REQ-017 Port o_alloc_cnt_r, output, 16 bits: saturating count of allocations.

Function
REQ-018 SHALL implement a two-state FSM, INIT and RUN; it SHALL reset to INIT, move INIT->RUN in the first cycle i_ad_busy_r==0, and never return to INIT except on reset.
REQ-019 SHALL hold a credit counter, width clog2(OUT_DEPTH)+1, reset value OUT_DEPTH, equal to free output entries minus in-flight lookups.
REQ-020 SHALL drive o_cmd_rdy = (state==RUN) & ~i_ad_empty_r & (credit!=0); o_cmd_rdy SHALL NOT depend on i_cmd_vld.
REQ-021 SHALL drive o_ad_alloc = i_cmd_vld & o_cmd_rdy (accept), combinationally in the AD cycle N.
REQ-022 On accept, credit SHALL decrement by 1; on output pop (o_out_vld & i_out_rdy), credit SHALL increment by 1; if both occur in one cycle, credit SHALL be unchanged.
REQ-023 Credit SHALL never exceed OUT_DEPTH nor underflow.
REQ-024 On accept in cycle N, the LK register (lk_vld, lk_data) SHALL capture i_cmd_data; lk_vld SHALL be 1 in cycle N+1.
REQ-025 In cycle N+1 with lk_vld=1, SHALL write {i_lk_ptr_w, lk_data} into the output FIFO; the entry SHALL be visible at o_out_* in cycle N+2.
REQ-026 Accept-to-o_out_vld latency SHALL be 2 cycles when the FIFO is empty; order SHALL be strictly FIFO.
REQ-027 Back-to-back accepts SHALL sustain 1 command per cycle while credit>0 and the pool is non-empty.
REQ-028 The output FIFO SHALL use wrapping read/write pointers; a simultaneous push and pop SHALL be legal at any occupancy, including full and empty.
REQ-029 o_out_ptr and o_out_data SHALL be stable while o_out_vld=1 and i_out_rdy=0.
REQ-030 o_alloc_cnt_r SHALL increment on each accept and saturate at 16'hFFFF.
REQ-031 i_ad_empty_r asserting with lk_vld=1 SHALL NOT affect the in-flight lookup.

Reset
REQ-032 On arst_n=0, the block SHALL immediately set: state=INIT, credit=OUT_DEPTH, lk_vld=0, FIFO pointers=0, o_out_vld=0, o_cmd_rdy=0, o_ad_alloc=0, o_alloc_cnt_r=0.
REQ-033 Reset mid-operation SHALL discard in-flight LK entries and FIFO contents; no output SHALL appear after reset until a new accept.
REQ-034 Datapath registers (lk_data, FIFO storage) SHALL need no reset.

Verification
REQ-035 Init: hold i_ad_busy_r=1 for 10 cycles, i_cmd_vld=1 -> o_cmd_rdy=0 and o_ad_alloc=0 throughout; o_cmd_rdy=1 in the cycle busy drops.
REQ-036 Latency: accept data 0xA5 at N, i_lk_ptr_w=0x12 at N+1 -> o_out_vld=1, o_out_ptr=0x12, o_out_data=0xA5 at N+2.
REQ-037 Backpressure: i_out_rdy=0 with streaming commands -> exactly 4 accepts, then o_cmd_rdy=0; one pop -> exactly one further accept.
REQ-038 Empty pool: i_ad_empty_r=1 -> o_cmd_rdy=0 and no o_ad_alloc; deassert -> accept resumes next cycle.
REQ-039 Full throughput: i_out_rdy=1 with 100 consecutive commands -> 100 in-order outputs, o_alloc_cnt_r=100, credit returns to 4.
REQ-040 Reset mid-stream with 3 entries queued -> o_out_vld=0 after reset and o_alloc_cnt_r=0; the next accept appears 2 cycles later.
